// File: rtl/ltc2315_emu_if.sv
// Serial link between the ADC master and the LTC2315 emulator.
// The master drives sck/cs; the emulator drives sdo and its output enable.
interface ltc2315_emu_if;
    logic sck;
    logic cs;
    logic sdo;
    logic sdo_oe;

    modport master (output sck, output cs, input sdo, input sdo_oe);
    modport slave  (input sck, input cs, output sdo, output sdo_oe);
endinterface

// File: rtl/ltc2315_emu.sv
// LTC2315 serial ADC emulator: one leading zero, DATA_W bits MSB first, then zeros.
// Define LTC2315_EMU_RAMP_EN to source conversions from an internal ramp instead of sample_in.
module ltc2315_emu #(
    parameter int unsigned       DATA_W    = 12,
    parameter logic [DATA_W-1:0] RAMP_STEP = 1,
    parameter int unsigned       LEAD_BITS = 1
) (
    input  logic              clk_100,
    input  logic              reset_n,
    ltc2315_emu_if.slave      spi,
    input  logic [DATA_W-1:0] sample_in,
    output logic [15:0]       conv_cnt,
    output logic              short_frame
);

    localparam int unsigned CNT_MAX = (DATA_W > LEAD_BITS) ? DATA_W : LEAD_BITS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {StIdle, StLead, StData, StTail} state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sdo_q, sdo_d;
    logic                oe_q, oe_d;
    logic                sf_q, sf_d;
    logic [15:0]         conv_q, conv_d;
    logic [DATA_W-1:0]   word;

    // meta -> sync -> history; resets high so release never looks like a falling edge
    logic [2:0] sck_q, cs_q;
    logic       sck_fall, cs_fall, cs_rise;

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            sck_q <= 3'b111;
            cs_q  <= 3'b111;
        end else begin
            sck_q <= {sck_q[1:0], spi.sck};
            cs_q  <= {cs_q[1:0], spi.cs};
        end
    end

    assign sck_fall = sck_q[2] & ~sck_q[1];
    assign cs_fall  = cs_q[2] & ~cs_q[1];
    assign cs_rise  = ~cs_q[2] & cs_q[1];

`ifdef LTC2315_EMU_RAMP_EN
    logic [DATA_W-1:0] ramp_q, ramp_d;

    assign word   = ramp_q;
    assign ramp_d = (state_q == StTail && cs_rise) ? ramp_q + RAMP_STEP : ramp_q;

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) ramp_q <= '0;
        else          ramp_q <= ramp_d;
    end
`else
    assign word = sample_in;
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        sdo_d   = sdo_q;
        oe_d    = oe_q;
        sf_d    = 1'b0;
        conv_d  = conv_q;
        unique case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    shift_d = word;
                    sdo_d   = 1'b0;
                    oe_d    = 1'b1;
                    cnt_d   = CNT_W'(LEAD_BITS);
                    state_d = StLead;
                end
            end
            StLead, StData: begin
                // cs rise wins over a coincident sck fall: the frame is abandoned unshifted
                if (cs_rise) begin
                    sf_d    = 1'b1;
                    sdo_d   = 1'b0;
                    oe_d    = 1'b0;
                    state_d = StIdle;
                end else if (sck_fall) begin
                    if (state_q == StLead) begin
                        if (cnt_q <= CNT_W'(1)) begin
                            sdo_d   = shift_q[DATA_W-1];
                            cnt_d   = CNT_W'(DATA_W - 1);
                            state_d = StData;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end else if (cnt_q == '0) begin
                        sdo_d   = 1'b0;
                        state_d = StTail;
                    end else begin
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        sdo_d   = shift_d[DATA_W-1];
                        cnt_d   = cnt_q - CNT_W'(1);
                    end
                end
            end
            StTail: begin
                if (cs_rise) begin
                    conv_d  = conv_q + 16'd1;
                    sdo_d   = 1'b0;
                    oe_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            sdo_q   <= 1'b0;
            oe_q    <= 1'b0;
            sf_q    <= 1'b0;
            conv_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            sdo_q   <= sdo_d;
            oe_q    <= oe_d;
            sf_q    <= sf_d;
            conv_q  <= conv_d;
        end
    end

    assign spi.sdo     = sdo_q;
    assign spi.sdo_oe  = oe_q;
    assign conv_cnt    = conv_q;
    assign short_frame = sf_q;

endmodule
